// File: rtl/regfile_mp_if.sv
// Register file bus: write ports, read ports, scoreboard issue and sweep-clear.
// The master drives requests; the slave returns read data, pending flags and busy.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     we0_i;
    logic [ADDR_W-1:0]        waddr0_i;
    logic [DATA_W-1:0]        wdata0_i;
    logic                     we1_i;
    logic [ADDR_W-1:0]        waddr1_i;
    logic [DATA_W-1:0]        wdata1_i;
    logic [NUM_RD*ADDR_W-1:0] raddr_i;
    logic [NUM_RD*DATA_W-1:0] rdata_o;
    logic [NUM_RD-1:0]        pend_o;
    logic                     issue_i;
    logic [ADDR_W-1:0]        issue_addr_i;
    logic                     clr_req_i;
    logic                     clr_busy_o;

    modport master (
        output we0_i, waddr0_i, wdata0_i,
        output we1_i, waddr1_i, wdata1_i,
        output raddr_i, issue_i, issue_addr_i, clr_req_i,
        input  rdata_o, pend_o, clr_busy_o
    );

    modport slave (
        input  we0_i, waddr0_i, wdata0_i,
        input  we1_i, waddr1_i, wdata1_i,
        input  raddr_i, issue_i, issue_addr_i, clr_req_i,
        output rdata_o, pend_o, clr_busy_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with r0 hardwired, pending scoreboard
// and sweep-clear. Define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy, start, last;
    logic              wr0, wr1, iss;

    assign busy  = (state_q == CLEAR);
    assign start = (state_q == IDLE) && bus.clr_req_i;
    assign last  = (cnt_q == ADDR_W'(DEPTH - 1));

    // All side effects are squashed while sweeping and for address 0.
    assign wr0 = bus.we0_i && !busy && (bus.waddr0_i != '0);
    assign wr1 = bus.we1_i && !busy && (bus.waddr1_i != '0);
    assign iss = bus.issue_i && !busy && (bus.issue_addr_i != '0);

    assign bus.clr_busy_o = busy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.clr_req_i) state_d = CLEAR;
            CLEAR: if (last) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) cnt_q <= ADDR_W'(1);
            else if (busy) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0) mem_q[bus.waddr0_i] <= bus.wdata0_i;
            if (wr1) mem_q[bus.waddr1_i] <= bus.wdata1_i;
        end
    end

    // Issue is applied after the write clears so a same-address issue wins.
    always_comb begin
        pend_d = pend_q;
        if (wr0) pend_d[bus.waddr0_i] = 1'b0;
        if (wr1) pend_d[bus.waddr1_i] = 1'b0;
        if (iss) pend_d[bus.issue_addr_i] = 1'b1;
        if (start || busy) pend_d = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else pend_q <= pend_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0, hit1;
        logic [DATA_W-1:0] rd;
        logic              pd;

        assign ra = bus.raddr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
        assign hit1 = wr1 && (bus.waddr1_i == ra);
        assign hit0 = wr0 && (bus.waddr0_i == ra);
`else
        assign hit1 = 1'b0;
        assign hit0 = 1'b0;
`endif

        always_comb begin
            rd = mem_q[ra];
            if (hit1) rd = bus.wdata1_i;
            else if (hit0) rd = bus.wdata0_i;
            if (!rst_ni) rd = '0;
        end

        assign pd = pend_q[ra] && !(hit0 || hit1) && !busy && rst_ni;

        assign bus.rdata_o[k*DATA_W +: DATA_W] = rd;
        assign bus.pend_o[k] = pd;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors, an abstract register/scoreboard
// model checked every cycle, and literal expectations for key scenarios.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd(int k);
        return bus.rdata_o[k*DATA_W +: DATA_W];
    endfunction

    // Abstract model: array contents, pending set, remaining sweep cycles.
    bit [31:0] m_mem [DEPTH];
    bit        m_pend [DEPTH];
    int        m_left = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = 0;
                m_pend[i] = 0;
            end
            m_left = 0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = 0;
            m_left--;
        end else begin
            if (bus.we0_i && bus.waddr0_i != 0) begin
                m_mem[bus.waddr0_i] = bus.wdata0_i;
                m_pend[bus.waddr0_i] = 0;
            end
            if (bus.we1_i && bus.waddr1_i != 0) begin
                m_mem[bus.waddr1_i] = bus.wdata1_i;
                m_pend[bus.waddr1_i] = 0;
            end
            if (bus.issue_i && bus.issue_addr_i != 0) m_pend[bus.issue_addr_i] = 1;
            if (bus.clr_req_i) begin
                m_left = DEPTH - 1;
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
            end
        end
    end

    logic [4:0]  c_a;
    logic [31:0] c_d;
    logic        c_p;
    logic        c_busy;

    always @(negedge clk_i) begin
        c_busy = (m_left > 0);
        chk("cmp_busy", {31'b0, bus.clr_busy_o}, {31'b0, c_busy});
        for (int k = 0; k < NUM_RD; k++) begin
            c_a = bus.raddr_i[k*ADDR_W +: ADDR_W];
            c_d = m_mem[c_a];
            c_p = m_pend[c_a];
            if (BYP && !c_busy && rst_ni && c_a != 0) begin
                if (bus.we1_i && bus.waddr1_i == c_a) begin
                    c_d = bus.wdata1_i;
                    c_p = 0;
                end else if (bus.we0_i && bus.waddr0_i == c_a) begin
                    c_d = bus.wdata0_i;
                    c_p = 0;
                end
            end
            if (c_busy || !rst_ni) c_p = 0;
            if (!rst_ni) c_d = 0;
            chk($sformatf("cmp_rdata%0d", k), rd(k), c_d);
            chk($sformatf("cmp_pend%0d", k), {31'b0, bus.pend_o[k]}, {31'b0, c_p});
        end
    end

    task automatic idle_in();
        bus.we0_i = 0; bus.waddr0_i = 0; bus.wdata0_i = 0;
        bus.we1_i = 0; bus.waddr1_i = 0; bus.wdata1_i = 0;
        bus.issue_i = 0; bus.issue_addr_i = 0; bus.clr_req_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int n;
        idle_in();
        bus.raddr_i = '0;
        rst_ni = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", {31'b0, bus.clr_busy_o}, 0);
        chk("rst_rd0", rd(0), 0);
        chk("rst_pend", {30'b0, bus.pend_o}, 0);
        rst_ni = 1;
        tick();

        // same address on both ports: port 1 wins
        bus.we0_i = 1; bus.waddr0_i = 5; bus.wdata0_i = 32'h11;
        bus.we1_i = 1; bus.waddr1_i = 5; bus.wdata1_i = 32'h22;
        bus.raddr_i = {5'd0, 5'd5};
        mid(); chk("same_now", rd(0), BYP ? 32'h22 : 32'h0);
        tick(); idle_in();
        mid(); chk("same_next", rd(0), 32'h22);
        tick();

        bus.we0_i = 1; bus.waddr0_i = 7; bus.wdata0_i = 32'hA5A5;
        bus.raddr_i = {5'd7, 5'd5};
        mid(); chk("r7_now", rd(1), BYP ? 32'hA5A5 : 32'h0);
        tick(); idle_in();
        mid(); chk("r7_next", rd(1), 32'hA5A5);
        tick();

        // register 0 stays zero
        bus.we0_i = 1; bus.waddr0_i = 0; bus.wdata0_i = 32'hFFFF_FFFF;
        bus.we1_i = 1; bus.waddr1_i = 0; bus.wdata1_i = 32'hFFFF_FFFF;
        bus.issue_i = 1; bus.issue_addr_i = 0;
        bus.raddr_i = {5'd0, 5'd0};
        mid(); chk("r0_now", rd(0), 0); chk("r0_pend_now", {30'b0, bus.pend_o}, 0);
        tick(); idle_in();
        mid(); chk("r0_next", rd(1), 0); chk("r0_pend_next", {30'b0, bus.pend_o}, 0);
        tick();

        // scoreboard
        bus.issue_i = 1; bus.issue_addr_i = 3;
        bus.raddr_i = {5'd3, 5'd3};
        tick(); idle_in();
        mid(); chk("sb_set", {31'b0, bus.pend_o[0]}, 1);
        bus.we0_i = 1; bus.waddr0_i = 3; bus.wdata0_i = 32'h33;
        bus.issue_i = 1; bus.issue_addr_i = 3;
        tick(); idle_in();
        mid(); chk("sb_both", {31'b0, bus.pend_o[0]}, 1);
        bus.we1_i = 1; bus.waddr1_i = 3; bus.wdata1_i = 32'h44;
        tick(); idle_in();
        mid(); chk("sb_clear", {31'b0, bus.pend_o[0]}, 0); chk("sb_data", rd(0), 32'h44);
        tick();

        // fill r1..r31 and sweep
        for (int i = 1; i < DEPTH; i += 2) begin
            bus.we0_i = 1; bus.waddr0_i = 5'(i); bus.wdata0_i = 32'h1000_0000 | i;
            bus.we1_i = (i + 1 < DEPTH); bus.waddr1_i = 5'(i + 1);
            bus.wdata1_i = 32'h1000_0000 | (i + 1);
            bus.issue_i = 1; bus.issue_addr_i = 5'd30;
            tick();
        end
        idle_in();
        bus.raddr_i = {5'd31, 5'd30};
        mid(); chk("fill_r31", rd(1), 32'h1000_001F); chk("fill_p30", {31'b0, bus.pend_o[0]}, 1);
        bus.clr_req_i = 1;
        tick(); idle_in();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus.clr_busy_o) break;
            n++;
            bus.we0_i = 1; bus.waddr0_i = 5'(c % 31 + 1); bus.wdata0_i = 32'hDEAD_BEEF;
            bus.we1_i = 1; bus.waddr1_i = 5'd31; bus.wdata1_i = 32'hBEEF_0000;
            bus.issue_i = 1; bus.issue_addr_i = 5'd2; bus.clr_req_i = 1;
            bus.raddr_i = {5'd31, 5'd2};
            tick();
        end
        idle_in();
        chk("sweep_len", n, 31);
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr_i = {5'(a), 5'(a)};
            #1;
            chk("swept", rd(0), 0);
        end
        chk("swept_pend", {30'b0, bus.pend_o}, 0);

        // first idle cycle accepts writes and issues
        bus.we0_i = 1; bus.waddr0_i = 9; bus.wdata0_i = 32'h99;
        bus.issue_i = 1; bus.issue_addr_i = 12;
        tick(); idle_in();
        bus.raddr_i = {5'd12, 5'd9};
        mid(); chk("post_wr", rd(0), 32'h99); chk("post_iss", {31'b0, bus.pend_o[1]}, 1);
        tick();

        // async reset mid-sweep
        bus.we0_i = 1; bus.waddr0_i = 20; bus.wdata0_i = 32'h2020;
        tick(); idle_in();
        bus.clr_req_i = 1;
        tick(); idle_in();
        bus.raddr_i = {5'd12, 5'd20};
        repeat (9) tick();
        mid();
        chk("mid_busy", {31'b0, bus.clr_busy_o}, 1);
        chk("mid_r20", rd(0), 32'h2020);
        rst_ni = 0;
        #1;
        chk("ar_busy", {31'b0, bus.clr_busy_o}, 0);
        chk("ar_rd0", rd(0), 0);
        chk("ar_pend", {30'b0, bus.pend_o}, 0);
        tick();
        rst_ni = 1;
        tick();
        chk("ar_idle", {31'b0, bus.clr_busy_o}, 0);
        bus.we1_i = 1; bus.waddr1_i = 20; bus.wdata1_i = 32'h77;
        tick(); idle_in();
        mid(); chk("ar_wr", rd(0), 32'h77);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports, NUM_RD >= 1.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- we0_i  in  1  write port 0 enable.
- waddr0_i  in  ADDR_W  write port 0 address.
- wdata0_i  in  DATA_W  write port 0 data.
- we1_i  in  1  write port 1 enable.
- waddr1_i  in  ADDR_W  write port 1 address.
- wdata1_i  in  DATA_W  write port 1 data.
- raddr_i  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata_o  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- pend_o  out  NUM_RD  pending flag of the register addressed by read port k.
- issue_i  in  1  mark issue_addr_i as having an outstanding producer.
- issue_addr_i  in  ADDR_W  register to mark pending.
- clr_req_i  in  1  request a full register sweep-clear.
- clr_busy_o  out  1  sweep-clear in progress.

Function
REQ-003 SHALL hardwire register 0 to zero: writes to address 0 are ignored, reads return 0, and pend is always 0.
REQ-004 SHALL commit writes on the rising clock edge; if both ports write the same address in one cycle, port 1 wins.
REQ-005 SHALL make reads combinational: each read port k selects, in priority order, wdata1_i (we1_i, waddr1_i==addr, addr!=0), then wdata0_i (same conditions), then the array (bypass; see REQ-013).
REQ-006 SHALL hold one pending bit per register, updated each cycle as follows:
- issue_i sets bit[issue_addr_i] (address 0 ignored).
- A write on either port clears bit[waddr].
- Set wins when issue and write hit the same address in the same cycle.
REQ-007 SHALL drive pend_o[k] combinationally as pend[raddr_k] AND NOT (bypassed write hitting raddr_k this cycle).
REQ-008 SHALL implement a two-state FSM, IDLE and CLEAR:
- IDLE -> CLEAR when clr_req_i=1.
- On entry to CLEAR: the sweep counter loads 1 and all pending bits clear.
- In CLEAR: register[counter] <= 0 each cycle and the counter increments.
- CLEAR -> IDLE in the cycle the counter writes DEPTH-1.
- A sweep takes exactly DEPTH-1 cycles.
REQ-009 SHALL assert clr_busy_o exactly while the state is CLEAR.
REQ-010 SHALL, while in CLEAR:
- Ignore we0_i, we1_i, issue_i and clr_req_i.
- Disable bypass; reads return array contents, which may be partially cleared.
- Drive pend_o to 0.
REQ-011 SHALL let writes and issues resume in the first cycle back in IDLE.

Reset
REQ-012 SHALL, on rst_ni=0 and independent of the clock:
- Clear all registers and all pending bits.
- Force state IDLE and counter 0.
- Hold clr_busy_o=0, rdata_o=0 for all ports, and pend_o=0.
- Abort any sweep in progress.
Normal operation resumes on the first clock edge after rst_ni returns to 1.

Configuration
REQ-013 SHALL compile the write-to-read bypass of REQ-005 and REQ-007 only when macro REGFILE_MP_BYPASS_EN is defined:
- Without the macro, reads return array contents only, so a write becomes visible the cycle after commit.
- Without the macro, pend_o[k] = pend[raddr_k].

Verification
REQ-014 SHALL be verified with these directed scenarios:
- Same-address write, defaults, bypass on: we0 r5=0x11, we1 r5=0x22 in one cycle -> rdata0 (raddr0=5) reads 0x22 that cycle; r5=0x22 next cycle.
- Bypass off (macro undefined): write r7=0xA5A5 -> rdata for r7 is old value 0 that cycle, 0xA5A5 next cycle.
- Register 0: write r0=0xFFFFFFFF on both ports -> rdata=0 and pend=0 always.
- Scoreboard: issue r3, next cycle pend=1; write r3 with issue r3 in the same cycle -> pend stays 1; write r3 alone -> pend=0 next cycle.
- Sweep-clear: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high exactly 31 cycles, writes during the sweep ignored, all registers read 0 afterwards.
- Async reset mid-sweep: assert rst_ni at sweep cycle 10 between edges -> clr_busy=0 and all outputs 0 immediately; IDLE after release.
